sram_controller: RTL

- Memory-side responder for the MEM stage's data-memory request interface (rd_en/wr_en/address/write_data -> read_data/ready).
- Services each 32-bit word access as two sequential 16-bit accesses to an external asynchronous SRAM, with a programmable wait time per access.
- Drives ready low while busy; the core freezes the pipeline on !ready.

---
 rtl/sram_controller_if.sv | 19 +
 rtl/sram_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage data-memory request bus between the core and the SRAM controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Data-memory responder: each 32-bit access becomes two timed 16-bit
// accesses (low half, then high half) to an external asynchronous SRAM.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave mem,
  output logic [17:0]      sram_addr,
  output logic [15:0]      sram_dq_out,
  output logic             sram_dq_oe,
  input  logic [15:0]      sram_dq_in,
  output logic             sram_we_n,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_ub_n,
  output logic             sram_lb_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [15:0] CNT_LAST     = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] CNT_PRE_LAST = 16'(WAIT_CYCLES - 2);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [16:0] word_q, word_d;
  logic [15:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;

  logic        req;
  logic [16:0] req_word;
  logic        phase_end;

  assign req       = mem.rd_en | mem.wr_en;
  // Only the low 17 bits of the word index reach the 18-bit half-word bus.
  assign req_word  = 17'((mem.address - 32'(BASE_ADDR)) >> 2);
  assign phase_end = (cnt_q == CNT_LAST);

  // Next-state logic. SRAM pins are computed one cycle ahead so the
  // registered outputs hold the right value throughout each phase cycle;
  // in particular we_n is raised when the counter reaches WAIT_CYCLES-2 so
  // that it is high during the final (hold) cycle of a write phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    word_d     = word_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    oe_d       = oe_q;
    we_n_d     = we_n_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LO;
          cnt_d      = '0;
          is_wr_d    = mem.wr_en;
          word_d     = req_word;
          wdata_hi_d = mem.write_data[31:16];
          addr_d     = {req_word, 1'b0};
          dq_out_d   = mem.write_data[15:0];
          oe_d       = mem.wr_en;
          we_n_d     = ~mem.wr_en;
        end
      end
      LO: begin
        if (phase_end) begin
          state_d  = HI;
          cnt_d    = '0;
          addr_d   = {word_q, 1'b1};
          dq_out_d = wdata_hi_q;
          we_n_d   = ~is_wr_q;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == CNT_PRE_LAST) we_n_d = 1'b1;
        end
      end
      HI: begin
        if (phase_end) begin
          state_d = DONE;
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == CNT_PRE_LAST) we_n_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered SRAM pins, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      oe_q       <= 1'b0;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      word_q     <= word_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      oe_q       <= oe_d;
      we_n_q     <= we_n_d;
    end
  end

  assign mem.read_data = rdata_q;
  assign mem.ready     = (state_q == IDLE) ? ~req : (state_q == DONE);

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_ce_n   = 1'b0;
  assign sram_oe_n   = 1'b0;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;

endmodule
